// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte queue and launch controller sitting directly in front of a UART
// transmitter. Producers push bytes at clock rate. The controller pops one
// byte at a time and presents it to the transmitter through a
// tx_data / tx_start / tx_busy handshake. Write order is preserved and every
// accepted byte is launched exactly once.
//
// Ports
//   clk       in   system clock; everything runs on its rising edge
//   rst       in   synchronous active-high reset (also resets the transmitter)
//   wr_data   in   byte to enqueue
//   wr_en     in   enqueue strobe, sampled every edge
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  bytes queued, excluding the byte handed to the transmitter
//   overflow  out  sticky; set when a write is dropped, cleared only by rst
//   tx_data   out  byte presented to the transmitter
//   tx_start  out  launch request to the transmitter
//   tx_busy   in   transmitter busy indication
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    wr_data,
   input  logic          wr_en,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic [7:0]    tx_data,
   output logic          tx_start,
   input  logic          tx_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SEND = 2'd2
   } state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          overflow_r;
   logic [7:0]    tx_data_r;
   state_t        state_r;
   state_t        state_s;

   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;

   // Flags come from the pre-edge count, so a write while full is dropped
   // even if a pop frees a slot on the same edge.
   assign full_s  = (count_r == FULL_CNT);
   assign empty_s = (count_r == {(AW+1){1'b0}});
   assign push_s  = wr_en & ~full_s;

   // Controller next-state logic; the pop happens on the IDLE -> REQ edge.
   always_comb begin
      state_s = state_r;
      pop_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (!empty_s) begin
               state_s = REQ;
               pop_s   = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            // A busy seen here is the transmitter accepting the request.
            if (tx_busy) begin
               state_s = SEND;
            end else begin
               state_s = REQ;
            end
         end
         SEND: begin
            if (!tx_busy) begin
               state_s = IDLE;
            end else begin
               state_s = SEND;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Storage array; reset wins over a simultaneous write.
   always_ff @(posedge clk) begin
      if (!rst && push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers, occupancy, overflow flag and the launched byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= {(AW+1){1'b0}};
         overflow_r <= 1'b0;
         tx_data_r  <= 8'h00;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r  <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            // tx_data only changes here, so it stays stable through REQ/SEND.
            tx_data_r <= mem_r[rd_ptr_r];
         end
         if (wr_en && full_s) begin
            overflow_r <= 1'b1;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

   // All outputs are registers or decodes of registers.
   assign full     = full_s;
   assign empty    = empty_s;
   assign count    = count_r;
   assign overflow = overflow_r;
   assign tx_data  = tx_data_r;
   assign tx_start = (state_r == REQ);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// Bench for uart_tx_fifo: a table of reset/handshake vectors, hand-written
// sequences for the multi-cycle corner cases, and a random phase. A small
// transmitter stub serialises accepted bytes; a queue-based reference model
// predicts the outputs every cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    wr_data;
   logic          wr_en;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic          tx_busy;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Transmitter stub: 10-bit frame, bp clocks per bit.
   logic       stub_en = 1'b0;
   logic       man_busy = 1'b0;
   logic       s_busy;
   logic       s_line;
   logic [9:0] s_sh;
   int         s_bit;
   int         s_cyc;
   int         bp = 2;
   logic [7:0] rx_q[$];

   assign tx_busy = stub_en ? s_busy : man_busy;

   always @(posedge clk) begin
      if (rst) begin
         s_busy <= 1'b0;
         s_line <= 1'b1;
         s_bit  <= 0;
         s_cyc  <= 0;
         rx_q.delete();
      end else if (!s_busy) begin
         if (stub_en && tx_start) begin
            s_busy <= 1'b1;
            s_sh   <= {1'b1, tx_data, 1'b0};
            s_line <= 1'b0;
            s_bit  <= 0;
            s_cyc  <= 0;
            rx_q.push_back(tx_data);
         end
      end else begin
         if (s_cyc == bp - 1) begin
            s_cyc <= 0;
            if (s_bit == 9) begin
               s_busy <= 1'b0;
               s_line <= 1'b1;
            end else begin
               s_bit  <= s_bit + 1;
               s_line <= s_sh[s_bit + 1];
            end
         end else begin
            s_cyc <= s_cyc + 1;
         end
      end
   end

   // Reference model: mq = bytes waiting, eq = every accepted byte in order,
   // m_phase 0 = waiting to launch, 1 = request outstanding, 2 = frame running.
   logic [7:0] mq[$];
   logic [7:0] eq[$];
   int         m_phase = 0;
   logic       m_ovf   = 1'b0;
   logic [7:0] m_txd   = 8'h00;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         eq.delete();
         m_phase <= 0;
         m_ovf   <= 1'b0;
         m_txd   <= 8'h00;
      end else begin
         if (m_phase == 0 && mq.size() > 0)      m_phase <= 1;
         else if (m_phase == 1 && tx_busy)       m_phase <= 2;
         else if (m_phase == 2 && !tx_busy)      m_phase <= 0;
         if (wr_en && mq.size() < DEPTH) begin
            if (m_phase == 0 && mq.size() > 0) m_txd <= mq.pop_front();
            mq.push_back(wr_data);
            eq.push_back(wr_data);
         end else begin
            if (wr_en) m_ovf <= 1'b1;
            if (m_phase == 0 && mq.size() > 0) m_txd <= mq.pop_front();
         end
      end
   end

   logic chk_en = 1'b0;

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cycle", {count, empty, full, overflow, tx_start, tx_data},
               {5'(mq.size()), 1'(mq.size() == 0), 1'(mq.size() == DEPTH),
                m_ovf, 1'(m_phase == 1), m_txd});
      end
   end

   typedef struct {
      logic       r;
      logic       we;
      logic [7:0] d;
      logic       busy;
      logic [4:0] cnt;
      logic       emp;
      logic       st;
      logic [7:0] txd;
   } vec_t;
   vec_t tbl[11];

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; wr_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int k = 0;
      while ((mq.size() != 0 || m_phase != 0 || s_busy) && k < 20000) begin
         @(negedge clk);
         k++;
      end
      check({name, "_drain_bound"}, 32'(k < 20000), 32'd1);
   endtask

   task automatic cmp_rx(input string name);
      check({name, "_frames"}, rx_q.size(), eq.size());
      for (int i = 0; i < rx_q.size() && i < eq.size(); i++) check(name, rx_q[i], eq[i]);
   endtask

   logic [9:0] exp_bits;
   int         pk;
   int         sent;
   int         k;
   logic       both_flag;

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
      //        rst   we    d      busy  cnt   emp   st    txd
      tbl[0]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00};
      tbl[1]  = '{1'b1, 1'b1, 8'hBB, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 1'b1, 8'h61, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00};
      tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h61};
      tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h61};
      tbl[5]  = '{1'b0, 1'b1, 8'h62, 1'b1, 5'd1, 1'b0, 1'b0, 8'h61};
      tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 8'h61};
      tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 8'h61};
      tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h62};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h62};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h62};

      // Reset under write, then single-byte handshake with a hand-driven busy.
      @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         rst = tbl[i].r; wr_en = tbl[i].we; wr_data = tbl[i].d; man_busy = tbl[i].busy;
         @(negedge clk);
         check($sformatf("vec%0d", i), {count, empty, tx_start, tx_data, overflow},
               {tbl[i].cnt, tbl[i].emp, tbl[i].st, tbl[i].txd, 1'b0});
         if (i == 0) chk_en = 1'b1;
      end

      // Single byte with serial line check, 10 clocks per bit.
      do_reset();
      bp = 10; stub_en = 1'b1;
      wr_en = 1'b1; wr_data = 8'h61;
      @(negedge clk);
      wr_en = 1'b0;
      exp_bits = {1'b1, 8'h61, 1'b0};
      k = 0;
      while (s_line !== 1'b0 && k < 50) begin @(negedge clk); k++; end
      check("single_start_bound", 32'(k < 50), 32'd1);
      repeat (bp / 2) @(negedge clk);
      for (int b = 0; b < 10; b++) begin
         check($sformatf("single_bit%0d", b), s_line, exp_bits[b]);
         if (b < 9) repeat (bp) @(negedge clk);
      end
      wait_drain("single");
      check("single_frames", rx_q.size(), 1);
      if (rx_q.size() > 0) check("single_byte", rx_q[0], 8'h61);

      // Burst of 16 consecutive writes.
      do_reset();
      bp = 2; pk = 0;
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
         @(negedge clk);
         if (int'(count) > pk) pk = int'(count);
      end
      wr_en = 1'b0;
      check("burst_peak", 32'(pk == 15 || pk == 16), 32'd1);
      wait_drain("burst");
      check("burst_frames", rx_q.size(), 16);
      for (int i = 0; i < rx_q.size() && i < 16; i++) check("burst_order", rx_q[i], 8'h10 + 8'(i));
      check("burst_end", {overflow, empty}, {1'b0, 1'b1});

      // Overflow with an unresponsive transmitter.
      do_reset();
      stub_en = 1'b0; man_busy = 1'b0;
      for (int i = 1; i <= 18; i++) begin
         wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
         @(negedge clk);
      end
      wr_en = 1'b0;
      check("ovf_state", {count, full, overflow, tx_start, tx_data},
            {5'd16, 1'b1, 1'b1, 1'b1, 8'hA1});
      bp = 1; stub_en = 1'b1;
      wait_drain("ovf");
      check("ovf_frames", rx_q.size(), 17);
      for (int i = 0; i < rx_q.size() && i < 17; i++) check("ovf_order", rx_q[i], 8'hA1 + 8'(i));

      // Stream 40 bytes keeping one entry queued; pointers wrap.
      do_reset();
      bp = 1;
      wr_en = 1'b1; wr_data = 8'($urandom); sent = 1;
      both_flag = 1'b0;
      k = 0;
      while ((sent < 40 || both_flag) && k < 5000) begin
         @(negedge clk);
         k++;
         if (both_flag) check("wrap_count_hold", count, 5'd1);
         if (sent < 40 && m_phase == 0 && mq.size() == 1) begin
            wr_en = 1'b1; wr_data = 8'($urandom); sent++; both_flag = 1'b1;
         end else begin
            wr_en = 1'b0; both_flag = 1'b0;
         end
      end
      wr_en = 1'b0;
      check("wrap_bound", 32'(k < 5000), 32'd1);
      wait_drain("wrap");
      check("wrap_accepted", eq.size(), 40);
      cmp_rx("wrap");

      // Reset in the middle of a frame with 3 bytes queued.
      do_reset();
      bp = 10;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 8'hC1 + 8'(i);
         @(negedge clk);
      end
      wr_en = 1'b0;
      check("mid_queued", count, 5'd3);
      k = 0;
      while (!(s_busy === 1'b1 && s_bit == 5) && k < 200) begin @(negedge clk); k++; end
      check("mid_bound", 32'(k < 200), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_after_rst", {tx_start, empty, count}, {1'b0, 1'b1, 5'd0});
      repeat (30) @(negedge clk);
      check("mid_nothing_sent", rx_q.size(), 0);
      wr_en = 1'b1; wr_data = 8'h55;
      @(negedge clk);
      wr_en = 1'b0;
      wait_drain("mid");
      check("mid_frames", rx_q.size(), 1);
      if (rx_q.size() > 0) check("mid_byte", rx_q[0], 8'h55);

      // Random traffic against the model.
      do_reset();
      bp = $urandom_range(1, 3);
      for (int i = 0; i < 400; i++) begin
         wr_en = ($urandom % 3 == 0);
         wr_data = 8'($urandom);
         @(negedge clk);
      end
      wr_en = 1'b0;
      wait_drain("rand");
      cmp_rx("rand");

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and launch controller directly upstream of the `uart` transmitter. Producers push bytes at clock rate; the block queues up to `DEPTH` bytes and presents them to the transmitter one at a time through the `tx_data` / `tx_start` / `tx_busy` handshake. Each byte is sent exactly once, and the order of writes is preserved. A single `tx_start` request is not held across frames, so the transmitter never re-sends stale data.

## Interface
- `DEPTH`, 16: FIFO entries. Must be a power of 2 and at least 2.
- `AW`, `$clog2(DEPTH)`: pointer width. Derived; do not override.
- `clk`  in  1  system clock. All logic is on its rising edge.
- `rst`  in  1  reset; one clock; synchronous, active-high.
- `wr_data`  in  8  byte to enqueue.
- `wr_en`  in  1  enqueue strobe; sampled every edge.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `count`  out  AW+1  bytes currently queued. Excludes the byte already handed to the transmitter.
- `overflow`  out  1  sticky flag; set when a write is dropped.
- `tx_data`  out  8  byte presented to `uart.tx_data`.
- `tx_start`  out  1  launch request to `uart.tx_start`.
- `tx_busy`  in  1  from `uart.tx_busy`.

## Operation
- **Storage:** `DEPTH`×8 register array, `wr_ptr`/`rd_ptr` of AW bits wrapping modulo `DEPTH`, and an explicit `count` register.
- **Write:** if `wr_en && !full` at an edge, `mem[wr_ptr] <= wr_data`, `wr_ptr++`.
  - `full` is evaluated on the pre-edge `count`.
  - A write while full is dropped, even if a pop happens on the same edge, and sets `overflow`.
- **Count:** `+1` on accepted write only, `-1` on pop only, unchanged on both or neither. Never exceeds `DEPTH` and never underflows.
- **Controller FSM** (states IDLE, REQ, SEND):
  - **IDLE:** `tx_start = 0`. At an edge with `!empty`: `tx_data <= mem[rd_ptr]`, `rd_ptr++`, pop, `tx_start <= 1`, go to REQ.
  - **REQ:** `tx_start` holds at 1 and `tx_data` is stable. At an edge with `tx_busy == 1`: `tx_start <= 0`, go to SEND. Wait indefinitely otherwise.
  - **SEND:** at an edge with `tx_busy == 0`, go to IDLE.
- **Data hold:** `tx_data` stays unchanged from the pop until the next pop. It is never modified in REQ or SEND.
- **Stale busy:** if `tx_busy` is already 1 when REQ is entered, it is treated as acceptance. Driving it that way is illegal; the bench must not do so.
- **Reset:**
  - All state cleared: pointers 0, `count` 0, state IDLE.
  - Queued bytes are discarded.
  - `rst` also resets the transmitter, so a frame in flight is abandoned.
  - Reset wins over a simultaneous `wr_en`.
- **`overflow`:** cleared only by `rst`.

## Timing
- **Reset values:** `full` 0, `empty` 1, `count` 0, `overflow` 0, `tx_data` 8'h00, `tx_start` 0.
- **Registered outputs:** all outputs are registered or decoded from registers only. No combinational path from any input to any output.
- **Write latency:** write accepted at edge E, then `empty` falls after E.
- **Launch latency (from IDLE):**
  - Write at edge E, pop at edge E+1, so `tx_start` rises after E+1.
  - The queued byte is visible on `tx_data` in the same cycle `tx_start` rises.
- **Request drop:** `tx_start` falls one edge after the first sampled `tx_busy == 1`. It overlaps `tx_busy` for exactly one cycle.
- **Inter-frame gap:** at least one IDLE cycle between `tx_busy` falling and the next `tx_start` rising.
  - Back-to-back bytes: `tx_start` re-rises 2 edges after `tx_busy` is first sampled low.
- **Throughput:** at most one pop per transmitter frame. The write side can accept one byte per clock.

## Test plan
- **Reset:**
  - Stimulus: `rst` high for 2 cycles while `wr_en` = 1.
  - Response: `empty` = 1, `count` = 0, `overflow` = 0, `tx_start` = 0, `tx_data` = 8'h00; nothing is queued.
- **Single byte:**
  - Stimulus: write "a" (8'h61) at edge E, with the `uart` instance at BAUD 1200000 and a 12 MHz clock.
  - Response:
    - `tx_start` high after E+1 with `tx_data` = 8'h61.
    - Serial line shows start 0, bits LSB-first 1,0,0,0,0,1,1,0, then stop 1.
    - `tx_start` is 0 from the cycle after `tx_busy` rises.
    - Exactly one frame is sent.
- **Burst ordering:**
  - Stimulus: write 8'h10..8'h1F on 16 consecutive clocks (DEPTH = 16).
  - Response:
    - `count` peaks at 15 or 16.
    - 16 frames decoded in order 8'h10..8'h1F.
    - `overflow` = 0; `empty` = 1 at the end.
- **Overflow:**
  - Stimulus: hold `tx_busy` = 0 and `tx_start` unacknowledged (stub the uart), then write 18 bytes.
  - Response:
    - One byte sits in `tx_data`; `count` = 16, `full` = 1.
    - The 18th write is dropped and `overflow` = 1.
    - After draining, only bytes 1–17 appear.
- **Simultaneous write and pop with wrap:**
  - Stimulus: keep the FIFO at 1 entry while streaming 40 bytes, so the pointers wrap at least twice.
  - Response: `count` stays unchanged on edges that both push and pop, and all 40 bytes are received in order.
- **Reset mid-frame:**
  - Stimulus: assert `rst` for 1 cycle during bit 4 of a frame, with 3 bytes queued.
  - Response:
    - `tx_start` = 0 and `empty` = 1 next cycle.
    - No queued byte is ever transmitted.
    - A subsequent write of 8'h55 transmits correctly.
